// File: rtl/instruction_memory_master_if.sv
// Client request/response and memory-side signals of the
// instruction memory master, with block-side and environment-side views.
interface instruction_memory_master_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [31:0] req_address;
   logic [31:0] req_data;
   logic [2:0]  req_burst;
   logic        resp_valid;
   logic [31:0] resp_data;
   logic        resp_last;
   logic        resp_error;
   logic        busy;
   logic [31:0] mem_address;
   logic        mem_mode;
   logic [31:0] mem_data_in;
   logic [31:0] mem_data_out;

   modport master (
      input  req_valid,
      input  req_write,
      input  req_address,
      input  req_data,
      input  req_burst,
      input  mem_data_out,
      output req_ready,
      output resp_valid,
      output resp_data,
      output resp_last,
      output resp_error,
      output busy,
      output mem_address,
      output mem_mode,
      output mem_data_in
   );

   modport slave (
      output req_valid,
      output req_write,
      output req_address,
      output req_data,
      output req_burst,
      output mem_data_out,
      input  req_ready,
      input  resp_valid,
      input  resp_data,
      input  resp_last,
      input  resp_error,
      input  busy,
      input  mem_address,
      input  mem_mode,
      input  mem_data_in
   );
endinterface

// File: rtl/instruction_memory_master.sv
// Single-request memory master: one-cycle writes and pipelined
// read bursts against a memory with one cycle of read latency.
module instruction_memory_master #(
   parameter int MEM_SIZE  = 80,
   parameter int MAX_BURST = 4
) (
   input logic                         clock,
   input logic                         reset_n,
   instruction_memory_master_if.master bus
);

   typedef enum logic [1:0] {
      IDLE,
      WRITE,
      READ
   } state_t;

   localparam logic [31:0] LIMIT = 32'(MEM_SIZE);
   localparam logic [3:0]  MAXB  = 4'(MAX_BURST);

   state_t      state;
   state_t      state_n;

   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [3:0]  len_q;
   logic [3:0]  iss_q;
   logic [3:0]  len_eff;
   logic [3:0]  burst4;
   logic [3:0]  iss_nx;

   logic        accept;
   logic        issue;
   logic        in_range;
   logic        ready;

   logic        p_v;
   logic        p_last;
   logic        p_err;

   logic        rv_q;
   logic [31:0] rd_q;
   logic        rl_q;
   logic        re_q;

   assign ready    = (state == IDLE) && reset_n;
   assign accept   = bus.req_valid && ready;
   assign issue    = (state == READ) && (iss_q < len_q);
   assign in_range = addr_q < LIMIT;
   assign iss_nx   = iss_q + 4'd1;
   assign burst4   = {1'b0, bus.req_burst};

   always_comb begin
      len_eff = burst4;
      if (burst4 == 4'd0)
         len_eff = 4'd1;
      else if (burst4 > MAXB)
         len_eff = MAXB;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         state <= IDLE;
      else
         state <= state_n;
   end

   // READ stays until the last beat leaves the capture stage
   always_comb begin
      state_n = state;
      unique case (state)
         IDLE: begin
            if (accept)
               state_n = bus.req_write ? WRITE : READ;
         end
         WRITE: state_n = IDLE;
         READ: begin
            if (p_v && p_last)
               state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         addr_q  <= '0;
         wdata_q <= '0;
         len_q   <= '0;
         iss_q   <= '0;
         p_v     <= 1'b0;
         p_last  <= 1'b0;
         p_err   <= 1'b0;
         rv_q    <= 1'b0;
         rd_q    <= '0;
         rl_q    <= 1'b0;
         re_q    <= 1'b0;
      end else begin
         p_v    <= 1'b0;
         p_last <= 1'b0;
         p_err  <= 1'b0;
         rv_q   <= 1'b0;
         rd_q   <= '0;
         rl_q   <= 1'b0;
         re_q   <= 1'b0;
         if (accept) begin
            addr_q  <= bus.req_address;
            wdata_q <= bus.req_data;
            len_q   <= len_eff;
            iss_q   <= '0;
         end
         if (state == WRITE) begin
            rv_q <= 1'b1;
            rl_q <= 1'b1;
            re_q <= !in_range;
         end
         // address holds on the final beat so IDLE keeps it
         if (issue) begin
            p_v    <= 1'b1;
            p_last <= (iss_nx == len_q);
            p_err  <= !in_range;
            iss_q  <= iss_nx;
            if (iss_nx < len_q)
               addr_q <= addr_q + 32'd1;
         end
         if (p_v) begin
            rv_q <= 1'b1;
            rl_q <= p_last;
            re_q <= p_err;
            rd_q <= p_err ? 32'd0 : bus.mem_data_out;
         end
      end
   end

   assign bus.req_ready   = ready;
   assign bus.busy        = (state != IDLE);
   assign bus.mem_mode    = (state == WRITE) && in_range;
   assign bus.mem_address = addr_q;
   assign bus.mem_data_in = wdata_q;
   assign bus.resp_valid  = rv_q;
   assign bus.resp_data   = rd_q;
   assign bus.resp_last   = rl_q;
   assign bus.resp_error  = re_q;

endmodule

// File: doc/instruction_memory_master.md
INSTRUCTION_MEMORY_MASTER -- requirements
Module: instruction_memory_master

Interface
REQ-001 SHALL have parameter MEM_SIZE, default 80: number of words in the attached word-addressed memory; valid addresses 0..MEM_SIZE-1.
REQ-002 SHALL have parameter MAX_BURST, default 4: maximum read beats per request.
REQ-003 SHALL have ports, in order:
  clock  input  1  single clock, all state on rising edge
  reset_n  input  1  asynchronous, active-low reset
  req_valid  input  1  client request present
  req_ready  output  1  block can accept a request
  req_write  input  1  1 = write, 0 = read
  req_address  input  32  start word address
  req_data  input  32  write data
  req_burst  input  3  read beat count; 0 treated as 1, values >MAX_BURST clamped to MAX_BURST
  resp_valid  output  1  one-cycle pulse per completed beat
  resp_data  output  32  read data for the beat, 0 for writes
  resp_last  output  1  final beat of the request
  resp_error  output  1  beat address >= MEM_SIZE
  busy  output  1  request in progress
  mem_address  output  32  memory address
  mem_mode  output  1  1 = write, 0 = read
  mem_data_in  output  32  memory write data
  mem_data_out  input  32  memory read data, registered by memory on the clock edge it samples mem_mode=0

Function
REQ-004 SHALL implement states IDLE, WRITE and READ; busy = (state != IDLE).
REQ-005 req_ready SHALL be 1 exactly when state = IDLE and reset_n = 1; a request is accepted on a rising edge with req_valid & req_ready.
REQ-006 On acceptance SHALL latch address, data, write flag and effective burst length, then go to WRITE if write, else READ.
REQ-007 mem_mode SHALL be 0 in every cycle except the single WRITE cycle; in IDLE, mem_address and mem_data_in SHALL hold their last values.
REQ-008 WRITE, one cycle: mem_address = latched address, mem_data_in = latched data, mem_mode = 1.
REQ-009 WRITE, out-of-range address: mem_mode SHALL be forced to 0 instead.
REQ-010 After WRITE SHALL return to IDLE and pulse resp_valid=1, resp_last=1, resp_data=0 in the next cycle; resp_error=1 if out of range.
REQ-011 Beat k address SHALL be latched address + k, modulo 2^32; range check is per beat address.
REQ-012 READ SHALL issue one beat address per cycle on mem_address, beats 0..N-1 in consecutive cycles, no gaps.
REQ-013 READ SHALL sample mem_data_out in the cycle after each issue.
REQ-014 Beat k SHALL appear on resp_data with resp_valid=1 two cycles after it is issued; beats are contiguous.
REQ-015 resp_last SHALL be 1 only on beat N-1.
REQ-016 First read beat SHALL have resp_valid high in the third cycle after the accepting edge; a write response appears in the second cycle.
REQ-017 READ SHALL return to IDLE on the edge on which the last beat is captured.
REQ-018 An out-of-range read beat SHALL set resp_data=0 and resp_error=1; other beats of the same burst are unaffected.
REQ-019 resp_valid, resp_last and resp_error SHALL be 0 in every cycle not carrying a beat.
REQ-020 The response channel has no backpressure; the client SHALL accept every beat.
REQ-021 A new request is accepted the edge after IDLE is re-entered; req_valid while busy is ignored and not queued.

Reset
REQ-022 While reset_n=0: state IDLE; req_ready=0, busy=0, resp_valid=0, resp_last=0, resp_error=0, resp_data=0, mem_mode=0, mem_address=0, mem_data_in=0.
REQ-023 Reset assertion mid-burst SHALL discard the in-flight request immediately, with no further resp_valid pulses and no memory write.
REQ-024 req_ready SHALL be 1 in the first cycle after reset_n rises.

Verification
REQ-025 Read, address 0, burst 1, memory word 0 = 0x1003c1e0 -> one resp_valid, resp_data=0x1003c1e0, resp_last=1, resp_error=0, in the 3rd cycle after acceptance.
REQ-026 Read, address 2, burst 4 -> four consecutive beats with words 2..5; resp_last only on the 4th; busy high throughout; req_ready low until IDLE.
REQ-027 Write 0xDEADBEEF to address 40, then read address 40, burst 1 -> mem_mode=1 for exactly one cycle; write response resp_data=0; read returns 0xDEADBEEF.
REQ-028 Read, address 78, burst 3 -> beats 78 and 79 return data with resp_error=0; beat 80 returns resp_data=0, resp_error=1, resp_last=1.
REQ-029 Write to address 100 -> mem_mode never 1; single response with resp_error=1; memory contents unchanged.
REQ-030 reset_n pulsed low after the 2nd beat of a 4-beat read -> no further resp_valid; all outputs at reset values; new request accepted the cycle after release.
